alu_cmd_ctrl: RTL and testbench

Command-side controller that drives the ALU interface: accepts one operation at a time from the instruction decoder over a valid/ready handshake, reads operands from an internal 8x16 register file, issues alu_enable/opcode/term1/term2, holds them until the ALU raises done, then writes the result back, updates a flag register and returns a one-cycle response. Sits between the decoder and the ALU as the initiator of the ALU protocol.

---
 rtl/alu_cmd_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Decoder-to-ALU command controller: latches one command, drives the ALU
// request until done or timeout, writes back R[dst]/flags and pulses a response.
module alu_cmd_ctrl #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 6,
  parameter int REG_CNT = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_opcode,
  input  logic [$clog2(REG_CNT)-1:0] cmd_dst,
  input  logic [$clog2(REG_CNT)-1:0] cmd_src,
  input  logic                       cmd_use_imm,
  input  logic [DATA_W-1:0]          cmd_imm,
  output logic                       alu_enable,
  output logic [OP_W-1:0]            alu_opcode,
  output logic [DATA_W-1:0]          alu_term1,
  output logic [DATA_W-1:0]          alu_term2,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic                       alu_fl_zero,
  input  logic                       alu_fl_negative,
  input  logic                       alu_fl_carry,
  input  logic                       alu_fl_overflow,
  input  logic                       alu_done,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_result,
  output logic [3:0]                 rsp_flags,
  output logic                       rsp_err,
  output logic [3:0]                 flags_q,
  input  logic [$clog2(REG_CNT)-1:0] dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);
  localparam int AW = $clog2(REG_CNT);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(8);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(9);
  localparam logic [OP_W-1:0] OP_TST = OP_W'(15);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(16);
  localparam logic [OP_W-1:0] OP_DEC = OP_W'(17);
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(17);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_regs [REG_CNT];
  logic [AW-1:0]       r_dst;
  logic                r_wb;
  logic [CW-1:0]       r_cnt;

  logic [DATA_W-1:0]   w_t1;
  logic [DATA_W-1:0]   w_t2;
  logic                w_reject;
  logic                w_wb;
  logic [3:0]          w_alu_fl;

  assign w_alu_fl  = {alu_fl_zero, alu_fl_negative, alu_fl_carry, alu_fl_overflow};
  assign cmd_ready = (r_state == S_IDLE) && !rst_b;
  assign dbg_data  = r_regs[dbg_addr];

  // Unary ops present a zero second term; the divide-by-zero check sees that final term2.
  always_comb begin
    w_t1 = r_regs[cmd_dst];
    w_t2 = cmd_use_imm ? cmd_imm : r_regs[cmd_src];
    if (cmd_opcode == OP_NOT || cmd_opcode == OP_INC || cmd_opcode == OP_DEC)
      w_t2 = '0;
    w_reject = (cmd_opcode > OP_MAX) ||
               ((cmd_opcode == OP_DIV || cmd_opcode == OP_MOD) && (w_t2 == '0));
    w_wb     = !(cmd_opcode == OP_CMP || cmd_opcode == OP_TST);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
      r_dst      <= '0;
      r_wb       <= 1'b0;
      r_cnt      <= '0;
      flags_q    <= '0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_term1  <= '0;
      alu_term2  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            if (w_reject) begin
              r_state    <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= flags_q;
            end else begin
              r_state    <= S_EXEC;
              alu_enable <= 1'b1;
              alu_opcode <= cmd_opcode;
              alu_term1  <= w_t1;
              alu_term2  <= w_t2;
              r_dst      <= cmd_dst;
              r_wb       <= w_wb;
              r_cnt      <= '0;
            end
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            if (r_wb) r_regs[r_dst] <= alu_result;
            flags_q    <= w_alu_fl;
            alu_enable <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_flags  <= w_alu_fl;
            rsp_err    <= 1'b0;
            r_state    <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // TIMEOUT-th request cycle without done: abandon, architectural state untouched
            alu_enable <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_flags  <= flags_q;
            rsp_err    <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Random + directed bench for alu_cmd_ctrl with a command-level reference model
// and a behavioural ALU responder of configurable done latency.
module tb_alu_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_opcode = '0;
  logic [2:0]  cmd_dst = '0, cmd_src = '0;
  logic        cmd_use_imm = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic        alu_enable;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_term1, alu_term2;
  logic [15:0] alu_result = '0;
  logic        alu_fl_zero = 1'b0, alu_fl_negative = 1'b0, alu_fl_carry = 1'b0, alu_fl_overflow = 1'b0;
  logic        alu_done = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  flags_q;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  alu_cmd_ctrl dut (
    .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .alu_enable(alu_enable),
    .alu_opcode(alu_opcode), .alu_term1(alu_term1), .alu_term2(alu_term2),
    .alu_result(alu_result), .alu_fl_zero(alu_fl_zero), .alu_fl_negative(alu_fl_negative),
    .alu_fl_carry(alu_fl_carry), .alu_fl_overflow(alu_fl_overflow), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .flags_q(flags_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: returns {Z,N,C,V,result}
  function automatic logic [19:0] alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      6'd0:  begin w = a + b; r = w[15:0]; c = w[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      6'd1, 6'd9: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      6'd2:  r = a * b;
      6'd3:  r = (b == '0) ? '1 : a / b;
      6'd4:  r = (b == '0) ? '1 : a % b;
      6'd5, 6'd15: r = a & b;
      6'd6:  r = a | b;
      6'd7:  r = a ^ b;
      6'd8:  r = ~a;
      6'd10: r = b;
      6'd11: r = {a[0], a[15:1]};
      6'd12: r = {a[14:0], a[15]};
      6'd13: r = a >> b[3:0];
      6'd14: r = a << b[3:0];
      6'd16: begin w = a + 16'd1; r = w[15:0]; c = w[16]; end
      6'd17: begin r = a - 16'd1; c = (a == '0); end
      default: r = '0;
    endcase
    return {(r == '0), r[15], c, v, r};
  endfunction

  int alu_lat = 0;   // -1 = never complete
  int en_cnt = 0;
  int en_total = 0;
  always @(negedge clk) begin
    logic [19:0] o;
    if (alu_enable) begin
      en_cnt++;
      en_total++;
      if (alu_lat >= 0 && en_cnt == alu_lat + 1) begin
        o = alu_fn(alu_opcode, alu_term1, alu_term2);
        alu_done = 1'b1;
        alu_result = o[15:0];
        {alu_fl_zero, alu_fl_negative, alu_fl_carry, alu_fl_overflow} = o[19:16];
      end else begin
        alu_done = 1'b0;
        alu_result = 16'($urandom);
        {alu_fl_zero, alu_fl_negative, alu_fl_carry, alu_fl_overflow} = 4'($urandom);
      end
    end else begin
      en_cnt = 0;
      // stray done pulses outside EXEC must be ignored by the controller
      alu_done = ($urandom_range(0, 3) == 0);
      alu_result = 16'($urandom);
      {alu_fl_zero, alu_fl_negative, alu_fl_carry, alu_fl_overflow} = 4'($urandom);
    end
  end

  // Reference model state and current expectations
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  logic        exp_active = 1'b0;
  logic [5:0]  exp_op;
  logic [15:0] exp_t1, exp_t2, exp_res;
  logic [3:0]  exp_fl;
  logic        exp_err;

  // Compare process: request terms while enabled, response fields on the pulse
  always @(negedge clk) begin
    if (exp_active) begin
      if (alu_enable) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(exp_op));
        chk("alu_term1", 32'(alu_term1), 32'(exp_t1));
        chk("alu_term2", 32'(alu_term2), 32'(exp_t2));
      end
      if (rsp_valid) begin
        chk("rsp_result", 32'(rsp_result), 32'(exp_res));
        chk("rsp_flags", 32'(rsp_flags), 32'(exp_fl));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("enable_in_resp", 32'(alu_enable), 32'd0);
      end
    end
  end

  task automatic run_cmd(input logic [5:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic ui, input logic [15:0] imm, input int lat);
    logic [15:0] t1, t2;
    logic [19:0] o;
    logic rej, tmo;
    int exp_lat, exp_en, w, k;
    t1 = m_regs[dst];
    t2 = (op == 6'd8 || op == 6'd16 || op == 6'd17) ? 16'd0 : (ui ? imm : m_regs[src]);
    rej = (op > 6'd17) || ((op == 6'd3 || op == 6'd4) && t2 == '0);
    tmo = !rej && (lat < 0 || lat > 63);
    exp_op = op; exp_t1 = t1; exp_t2 = t2;
    if (rej || tmo) begin
      exp_res = '0; exp_fl = m_flags; exp_err = 1'b1;
      exp_lat = rej ? 1 : 65;
      exp_en  = rej ? 0 : 64;
    end else begin
      o = alu_fn(op, t1, t2);
      exp_res = o[15:0]; exp_fl = o[19:16]; exp_err = 1'b0;
      exp_lat = lat + 2; exp_en = lat + 1;
      m_flags = o[19:16];
      if (op != 6'd9 && op != 6'd15) m_regs[dst] = o[15:0];
    end
    alu_lat = lat;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    if (!cmd_ready) begin chk("ready_wait", 32'd0, 32'd1); return; end
    cmd_opcode = op; cmd_dst = dst; cmd_src = src; cmd_use_imm = ui; cmd_imm = imm;
    cmd_valid = 1'b1;
    en_total = 0;
    exp_active = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_imm = 16'($urandom); cmd_src = 3'($urandom);
    k = 1;
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    chk("rsp_latency", 32'(k), 32'(exp_lat));
    chk("enable_cycles", 32'(en_total), 32'(exp_en));
    dbg_addr = dst; #1;
    chk("dbg_in_resp", 32'(dbg_data), 32'(m_regs[dst]));
    @(negedge clk);
    exp_active = 1'b0;
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("rsp_hold", 32'({rsp_err, rsp_flags, rsp_result}), 32'({exp_err, exp_fl, exp_res}));
    chk("ready_after", 32'(cmd_ready), 32'd1);
    chk("flags_q", 32'(flags_q), 32'(m_flags));
  endtask

  task automatic chk_dbg(input string name, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a; #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_reset_state();
    chk("rst_enable", 32'(alu_enable), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_flags, rsp_result}), 32'd0);
    chk("rst_flags_q", 32'(flags_q), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      chk("rst_reg", 32'(dbg_data), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    chk_reset_state();
    rst_b = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed, with literal expectations pinning the model
    run_cmd(6'h0A, 3'd1, 3'd0, 1'b1, 16'd5, 0);
    chk("lit_mov", 32'(rsp_result), 32'd5);
    run_cmd(6'h00, 3'd1, 3'd0, 1'b1, 16'd10, 0);
    chk("lit_add_res", 32'(rsp_result), 32'd15);
    chk("lit_add_flags", 32'(rsp_flags), 32'd0);
    chk_dbg("lit_r1", 3'd1, 16'd15);

    run_cmd(6'h0A, 3'd2, 3'd0, 1'b1, 16'h0030, 1);
    run_cmd(6'h09, 3'd2, 3'd0, 1'b1, 16'h0030, 2);
    chk("lit_cmp_flags", 32'(rsp_flags), 32'h8);
    chk("lit_cmp_flags_q", 32'(flags_q), 32'h8);
    chk_dbg("lit_r2", 3'd2, 16'h0030);

    run_cmd(6'h0A, 3'd3, 3'd0, 1'b1, 16'd7, 0);
    run_cmd(6'h00, 3'd0, 3'd0, 1'b1, 16'h0000, 0);   // zero result -> flags_q = 1000
    run_cmd(6'h03, 3'd3, 3'd0, 1'b1, 16'd0, 0);
    chk("lit_div0_err", 32'(rsp_err), 32'd1);
    chk("lit_div0_flags_q", 32'(flags_q), 32'h8);
    chk_dbg("lit_r3", 3'd3, 16'd7);

    run_cmd(6'h20, 3'd3, 3'd1, 1'b0, 16'd0, 0);
    chk("lit_badop_err", 32'(rsp_err), 32'd1);
    chk("lit_badop_res", 32'(rsp_result), 32'd0);

    run_cmd(6'h0A, 3'd4, 3'd0, 1'b1, 16'h1234, 0);
    run_cmd(6'h00, 3'd4, 3'd0, 1'b1, 16'd1, -1);
    chk("lit_tmo_err", 32'(rsp_err), 32'd1);
    chk_dbg("lit_tmo_r4", 3'd4, 16'h1234);
    run_cmd(6'h01, 3'd4, 3'd0, 1'b1, 16'd4, 5);
    chk("lit_lat5_res", 32'(rsp_result), 32'h1230);
    run_cmd(6'h00, 3'd5, 3'd4, 1'b0, 16'd0, 63);      // done on the last allowed cycle
    chk("lit_lat63_err", 32'(rsp_err), 32'd0);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int r, lat;
      op = (n % 13 == 12) ? 6'h3F : 6'($urandom_range(0, 19));
      r = int'($urandom_range(0, 24));
      lat = (r == 0) ? -1 : r % 7;
      run_cmd(op, 3'($urandom), 3'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), lat);
    end

    // Reset during EXEC discards the command
    alu_lat = 10;
    begin
      int w;
      w = 0;
      while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    end
    cmd_opcode = 6'h00; cmd_dst = 3'd1; cmd_src = 3'd0; cmd_use_imm = 1'b1; cmd_imm = 16'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_exec_enable", 32'(alu_enable), 32'd1);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("mid_rst_enable", 32'(alu_enable), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk_reset_state();
    rst_b = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0;
    run_cmd(6'h10, 3'd6, 3'd0, 1'b0, 16'd0, 1);
    chk("lit_inc_after_rst", 32'(rsp_result), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
